led_display_row_scheduler: RTL and testbench
============================================

// Module: led_display_row_scheduler
// PURPOSE
//  Sequences the LED matrix PHY (led_display_driver_phy) for binary-coded-modulation (BCM) colour depth.
//  For each row, fetches each bit plane from the frame buffer and hands the rgb_row_t to the PHY.
//  Waits for the PHY latch, then drives output enable for a plane-weighted display time.
//  Sits between the frame buffer read port and the PHY pixel-stream interface.
// PARAMETERS
//  NUM_ROWS      16   scanned row pairs; row index width 4
//  NUM_PLANES    4    colour bits per channel; plane p is weighted 2^p
//  BASE_TICKS    64   clk cycles OE is active for plane 0; plane p = BASE_TICKS<<p
//  LATCH_TIMEOUT 256  max cycles from row_valid_out to latch_in before error
// PORTS
//  clk_in             in   1         system clock
//  n_reset_in         in   1         asynchronous active-low reset
//  enable_in          in   1         run scan; sampled at plane boundaries
//  fb_rd_en_out       out  1         frame buffer read strobe, one cycle
//  fb_row_out         out  4         row index being read
//  fb_plane_out       out  PLANE_W   bit plane being read, PLANE_W=$clog2(NUM_PLANES)
//  fb_data_in         in   rgb_row_t plane data; valid exactly 1 cycle after fb_rd_en_out
//  row_valid_out      out  1         one-cycle PHY load strobe
//  row_out            out  rgb_row_t registered plane data to PHY
//  row_address_out    out  4         (row+1) mod 16; PHY presents address-1 at latch
//  row_ready_in       in   1         PHY ready
//  latch_in           in   1         PHY latch pulse
//  oe_n_out           out  1         panel output enable, active low
//  frame_done_out     out  1         one-cycle pulse after last row/last plane
//  error_out          out  1         sticky latch-timeout flag; cleared only by reset
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; row=0, plane=0
//   - all outputs 0 except oe_n_out=1; timers cleared
//  States:
//   - IDLE: oe_n=1. If enable_in -> FETCH.
//   - FETCH: fb_rd_en_out=1 for 1 cycle with fb_row_out/fb_plane_out -> WAIT.
//   - WAIT: capture fb_data_in into row_out -> SEND.
//   - SEND: when row_ready_in=1, assert row_valid_out for 1 cycle and start latch timer -> SHIFT.
//     Hold in SEND while row_ready_in=0.
//   - SHIFT: oe_n=1 (blank while shifting/latching). On latch_in=1 -> DISPLAY.
//     If the timer reaches LATCH_TIMEOUT, set error_out and go -> FETCH (same row/plane retried).
//   - DISPLAY: oe_n=0 for exactly BASE_TICKS<<plane cycles, then oe_n=1 and advance:
//     - plane<NUM_PLANES-1: plane++
//     - else: plane=0 and row++ (wraps NUM_ROWS-1 -> 0 with a frame_done_out pulse)
//     - then enable_in ? FETCH : IDLE
//  enable_in deassert mid-plane: the current DISPLAY completes; there is no truncation.
//  Simultaneous latch_in and timer expiry: latch_in wins, no error.
//  latch_in outside SHIFT is ignored.
//  Latency: FETCH to row_valid_out is 2 cycles minimum (ready high).
//  Display counter width is $clog2(BASE_TICKS<<(NUM_PLANES-1))+1. Compares are unsigned.
// STRUCTURE
//  Package led_display_package gains:
//   - GL_NUM_PLANES, GL_BCM_BASE_TICKS, GL_NUM_ROWS
//   - sched_state_t enum {IDLE,FETCH,WAIT,SEND,SHIFT,DISPLAY}
//  rgb_row_t is reused from the package.
//  Sub-module led_display_bcm_timer: load(count) input, done pulse output; reused for the display and latch timers.
// TESTING  (NUM_PLANES=2, BASE_TICKS=4, LATCH_TIMEOUT=40, PHY model)
//  1. Reset, enable=1:
//     - first fb_rd_en with row0/plane0
//     - row_valid 2 cycles later, row_address_out=1
//     - oe_n low 4 cycles after latch
//  2. Plane weighting:
//     - row0 plane1 gives oe_n low 8 cycles
//     - then fb_row_out=1, plane=0
//  3. Wrap: after row15 plane1 DISPLAY -> frame_done pulse, next fetch row0/plane0, error_out=0.
//  4. Hold row_ready_in=0 for 10 cycles in SEND -> no row_valid; strobes on first ready cycle.
//  5. Suppress latch_in -> error_out=1 at 40 cycles, same row/plane refetched; enable=0 mid-DISPLAY -> finishes then IDLE, oe_n=1.
//  6. Assert n_reset_in=0 mid-DISPLAY -> oe_n_out=1 and all strobes 0 immediately; restart at row0/plane0.

Source files
------------

// File: rtl/led_display_row_scheduler_pkg.sv
// Shared types and defaults for the LED display row scheduler.
//   rgb_row_t     : one bit plane of a row pair (upper/lower half RGB)
//   sched_state_t : scheduler FSM states
//   plane_w()     : index width for a given number of bit planes
package led_display_row_scheduler_pkg;

  localparam int unsigned GL_NUM_ROWS       = 16;
  localparam int unsigned GL_NUM_PLANES     = 4;
  localparam int unsigned GL_BCM_BASE_TICKS = 64;
  localparam int unsigned GL_LATCH_TIMEOUT  = 256;
  localparam int unsigned GL_NUM_COLS       = 32;
  localparam int unsigned GL_ROW_W          = 4;

  typedef struct packed {
    logic [GL_NUM_COLS-1:0] r0;
    logic [GL_NUM_COLS-1:0] g0;
    logic [GL_NUM_COLS-1:0] b0;
    logic [GL_NUM_COLS-1:0] r1;
    logic [GL_NUM_COLS-1:0] g1;
    logic [GL_NUM_COLS-1:0] b1;
  } rgb_row_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    SHIFT,
    DISPLAY
  } sched_state_t;

  function automatic int unsigned plane_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_display_row_scheduler_if.sv
// Bundle between the row scheduler, the frame buffer read port and the PHY.
//   master : scheduler side (drives fetch strobes, PHY load, OE, status)
//   slave  : frame buffer / PHY / control side
interface led_display_row_scheduler_if #(
  parameter int unsigned PLANE_W = 2
) ();

  logic                                           enable_in;
  logic                                           fb_rd_en_out;
  logic [led_display_row_scheduler_pkg::GL_ROW_W-1:0] fb_row_out;
  logic [PLANE_W-1:0]                             fb_plane_out;
  led_display_row_scheduler_pkg::rgb_row_t        fb_data_in;
  logic                                           row_valid_out;
  led_display_row_scheduler_pkg::rgb_row_t        row_out;
  logic [led_display_row_scheduler_pkg::GL_ROW_W-1:0] row_address_out;
  logic                                           row_ready_in;
  logic                                           latch_in;
  logic                                           oe_n_out;
  logic                                           frame_done_out;
  logic                                           error_out;

  modport master (
    input  enable_in, fb_data_in, row_ready_in, latch_in,
    output fb_rd_en_out, fb_row_out, fb_plane_out, row_valid_out, row_out,
           row_address_out, oe_n_out, frame_done_out, error_out
  );

  modport slave (
    output enable_in, fb_data_in, row_ready_in, latch_in,
    input  fb_rd_en_out, fb_row_out, fb_plane_out, row_valid_out, row_out,
           row_address_out, oe_n_out, frame_done_out, error_out
  );

endinterface

// File: rtl/led_display_bcm_timer.sv
// Down-counter used for both the BCM display window and the latch timeout.
//   load_in  : start a new interval of count_in cycles (count_in >= 1)
//   done_out : high during the last cycle of the interval, then idles
module led_display_bcm_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_in,
  input  logic         n_reset_in,
  input  logic         load_in,
  input  logic [W-1:0] count_in,
  output logic         done_out
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_in) begin
      cnt_d = count_in - W'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_out = run_q && (cnt_q == '0);

endmodule

// File: rtl/led_display_row_scheduler.sv
// BCM row scheduler: fetches each bit plane of each row from the frame
// buffer, loads it into the PHY, waits for the latch and then enables the
// panel for BASE_TICKS<<plane cycles.
//   clk_in, n_reset_in : clock, asynchronous active-low reset
//   bus (master)       : frame buffer read, PHY load/latch, OE and status
module led_display_row_scheduler
  import led_display_row_scheduler_pkg::*;
#(
  parameter int unsigned NUM_ROWS      = GL_NUM_ROWS,
  parameter int unsigned NUM_PLANES    = GL_NUM_PLANES,
  parameter int unsigned BASE_TICKS    = GL_BCM_BASE_TICKS,
  parameter int unsigned LATCH_TIMEOUT = GL_LATCH_TIMEOUT
) (
  input  logic                        clk_in,
  input  logic                        n_reset_in,
  led_display_row_scheduler_if.master bus
);

  localparam int unsigned PLANE_W = plane_w(NUM_PLANES);
  localparam int unsigned DCNT_W  = $clog2(BASE_TICKS << (NUM_PLANES - 1)) + 1;
  localparam int unsigned LCNT_W  = $clog2(LATCH_TIMEOUT) + 1;

  sched_state_t          state_q, state_d;
  logic [GL_ROW_W-1:0]   row_q, row_d;
  logic [PLANE_W-1:0]    plane_q, plane_d;
  logic [GL_ROW_W-1:0]   row_addr_q, row_addr_d;
  rgb_row_t              row_data_q, row_data_d;
  logic                  fb_rd_en_q, fb_rd_en_d;
  logic                  row_valid_q, row_valid_d;
  logic                  oe_n_q, oe_n_d;
  logic                  frame_done_q, frame_done_d;
  logic                  error_q, error_d;

  logic                  dtmr_load, dtmr_done;
  logic [DCNT_W-1:0]     dtmr_count;
  logic                  ltmr_load, ltmr_done;

  assign dtmr_count = DCNT_W'(BASE_TICKS) << plane_q;

  led_display_bcm_timer #(.W(DCNT_W)) u_display_timer (
    .clk_in     (clk_in),
    .n_reset_in (n_reset_in),
    .load_in    (dtmr_load),
    .count_in   (dtmr_count),
    .done_out   (dtmr_done)
  );

  led_display_bcm_timer #(.W(LCNT_W)) u_latch_timer (
    .clk_in     (clk_in),
    .n_reset_in (n_reset_in),
    .load_in    (ltmr_load),
    .count_in   (LCNT_W'(LATCH_TIMEOUT)),
    .done_out   (ltmr_done)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    plane_d      = plane_q;
    row_data_d   = row_data_q;
    fb_rd_en_d   = 1'b0;
    row_valid_d  = 1'b0;
    oe_n_d       = oe_n_q;
    frame_done_d = 1'b0;
    error_d      = error_q;
    dtmr_load    = 1'b0;
    ltmr_load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        oe_n_d = 1'b1;
        if (bus.enable_in) begin
          fb_rd_en_d = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      // Ready is looked at while capturing so the registered strobe still
      // lands two cycles after the fetch strobe; SEND only holds when the
      // PHY is busy.
      WAIT: begin
        row_data_d = bus.fb_data_in;
        if (bus.row_ready_in) begin
          row_valid_d = 1'b1;
          ltmr_load   = 1'b1;
          state_d     = SHIFT;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.row_ready_in) begin
          row_valid_d = 1'b1;
          ltmr_load   = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        oe_n_d = 1'b1;
        if (bus.latch_in) begin
          dtmr_load = 1'b1;
          oe_n_d    = 1'b0;
          state_d   = DISPLAY;
        end else if (ltmr_done) begin
          error_d    = 1'b1;
          fb_rd_en_d = 1'b1;
          state_d    = FETCH;
        end
      end
      DISPLAY: begin
        if (dtmr_done) begin
          oe_n_d = 1'b1;
          if (plane_q == PLANE_W'(NUM_PLANES - 1)) begin
            plane_d = '0;
            if (row_q == GL_ROW_W'(NUM_ROWS - 1)) begin
              row_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + GL_ROW_W'(1);
            end
          end else begin
            plane_d = plane_q + PLANE_W'(1);
          end
          if (bus.enable_in) begin
            fb_rd_en_d = 1'b1;
            state_d    = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    row_addr_d = (row_d == GL_ROW_W'(NUM_ROWS - 1)) ? '0 : row_d + GL_ROW_W'(1);
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q      <= IDLE;
      row_q        <= '0;
      plane_q      <= '0;
      row_addr_q   <= '0;
      row_data_q   <= '0;
      fb_rd_en_q   <= 1'b0;
      row_valid_q  <= 1'b0;
      oe_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      row_addr_q   <= row_addr_d;
      row_data_q   <= row_data_d;
      fb_rd_en_q   <= fb_rd_en_d;
      row_valid_q  <= row_valid_d;
      oe_n_q       <= oe_n_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
    end
  end

  assign bus.fb_rd_en_out    = fb_rd_en_q;
  assign bus.fb_row_out      = row_q;
  assign bus.fb_plane_out    = plane_q;
  assign bus.row_valid_out   = row_valid_q;
  assign bus.row_out         = row_data_q;
  assign bus.row_address_out = row_addr_q;
  assign bus.oe_n_out        = oe_n_q;
  assign bus.frame_done_out  = frame_done_q;
  assign bus.error_out       = error_q;

endmodule

// File: tb/tb_led_display_row_scheduler.sv
module tb_led_display_row_scheduler;
  import led_display_row_scheduler_pkg::*;

  localparam int unsigned NR = 16;
  localparam int unsigned NP = 2;
  localparam int unsigned BT = 4;
  localparam int unsigned LT = 40;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  led_display_row_scheduler_if #(.PLANE_W(1)) bus ();

  led_display_row_scheduler #(
    .NUM_ROWS      (NR),
    .NUM_PLANES    (NP),
    .BASE_TICKS    (BT),
    .LATCH_TIMEOUT (LT)
  ) dut (
    .clk_in     (clk),
    .n_reset_in (n_reset),
    .bus        (bus)
  );

  rgb_row_t mem [NR][NP];
  int n_assert = 0;
  int n_fail   = 0;
  int m_row, m_plane;
  logic m_err;
  bit fb_keep = 0;

  function automatic rgb_row_t rand_row();
    rgb_row_t r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  // Frame buffer: data valid for the cycle after the read strobe, noise otherwise.
  always @(negedge clk) begin
    if (bus.fb_rd_en_out === 1'b1) begin
      bus.fb_data_in = mem[bus.fb_row_out][bus.fb_plane_out];
      fb_keep = 1;
    end else if (fb_keep) begin
      fb_keep = 0;
    end else begin
      bus.fb_data_in = rand_row();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One plane transaction; entered at the negedge where the fetch strobe is expected.
  task automatic do_plane(input int ready_dly, input int latch_dly,
                          input bit drop_en, input bit rst_mid);
    int n_on;
    int idx;
    bit exp_fd;
    rgb_row_t exp_row;
    exp_row = mem[m_row][m_plane];
    check("fetch_strobe", bus.fb_rd_en_out, 1);
    check("fetch_row", bus.fb_row_out, m_row);
    check("fetch_plane", bus.fb_plane_out, m_plane);
    check("err_entry", bus.error_out, m_err);
    check("oe_fetch", bus.oe_n_out, 1);
    bus.row_ready_in = (ready_dly == 0);
    step();
    check("rd_one_cycle", bus.fb_rd_en_out, 0);
    check("no_early_valid", bus.row_valid_out, 0);
    check("frame_done_pulse", bus.frame_done_out, 0);
    for (int k = 0; k < ready_dly; k++) begin
      step();
      check("send_hold", bus.row_valid_out, 0);
    end
    bus.row_ready_in = 1;
    step();
    check("row_valid", bus.row_valid_out, 1);
    check("row_data", bus.row_out, exp_row);
    check("row_addr", bus.row_address_out, (m_row + 1) % NR);
    check("oe_shift", bus.oe_n_out, 1);
    bus.row_ready_in = 0;
    if (latch_dly < 0) begin
      for (int k = 1; k < LT; k++) begin
        step();
        check("oe_shift_wait", bus.oe_n_out, 1);
        check("valid_pulse", bus.row_valid_out, 0);
        check("err_not_yet", bus.error_out, m_err);
      end
      step();
      m_err = 1;
      check("err_set", bus.error_out, 1);
      check("refetch", bus.fb_rd_en_out, 1);
      check("oe_retry", bus.oe_n_out, 1);
      return;
    end
    for (int k = 0; k < latch_dly; k++) begin
      step();
      check("oe_shift_wait", bus.oe_n_out, 1);
      check("valid_pulse", bus.row_valid_out, 0);
      check("err_shift", bus.error_out, m_err);
    end
    bus.latch_in = 1;
    step();
    bus.latch_in = 0;
    n_on = BT * (2 ** m_plane);
    for (int j = 0; j < n_on; j++) begin
      check("oe_low", bus.oe_n_out, 0);
      check("valid_in_display", bus.row_valid_out, 0);
      check("err_display", bus.error_out, m_err);
      if (drop_en && j == 1) bus.enable_in = 0;
      if (rst_mid && j == 2) begin
        n_reset = 0;
        #1;
        check("rst_oe", bus.oe_n_out, 1);
        check("rst_rd_en", bus.fb_rd_en_out, 0);
        check("rst_valid", bus.row_valid_out, 0);
        check("rst_frame_done", bus.frame_done_out, 0);
        check("rst_err", bus.error_out, 0);
        check("rst_row", bus.fb_row_out, 0);
        check("rst_plane", bus.fb_plane_out, 0);
        m_row = 0; m_plane = 0; m_err = 0;
        return;
      end
      step();
    end
    check("oe_after", bus.oe_n_out, 1);
    idx = m_row * NP + m_plane + 1;
    exp_fd = (idx == NR * NP);
    if (exp_fd) idx = 0;
    m_row = idx / NP;
    m_plane = idx % NP;
    check("frame_done", bus.frame_done_out, exp_fd);
    check("next_fetch", bus.fb_rd_en_out, bus.enable_in);
    check("err_after", bus.error_out, m_err);
  endtask

  initial begin
    int rd, ld;
    for (int r = 0; r < NR; r++)
      for (int p = 0; p < NP; p++)
        mem[r][p] = rand_row();
    bus.enable_in = 0;
    bus.row_ready_in = 0;
    bus.latch_in = 0;
    bus.fb_data_in = rand_row();
    n_reset = 0;
    repeat (3) step();

    check("reset_oe", bus.oe_n_out, 1);
    check("reset_rd_en", bus.fb_rd_en_out, 0);
    check("reset_valid", bus.row_valid_out, 0);
    check("reset_frame_done", bus.frame_done_out, 0);
    check("reset_err", bus.error_out, 0);
    check("reset_row", bus.fb_row_out, 0);
    check("reset_row_addr", bus.row_address_out, 0);

    bus.enable_in = 1;
    n_reset = 1;
    step();
    m_row = 0; m_plane = 0; m_err = 0;

    // Full frame with random PHY timing; includes the latch-at-timeout boundary
    // and a long not-ready hold.
    for (int i = 0; i < NR * NP; i++) begin
      rd = (i == 0) ? 0 : (i == 7) ? 10 : int'($urandom_range(0, 2));
      ld = (i == 5) ? LT - 1 : int'($urandom_range(0, 6));
      do_plane(rd, ld, 0, 0);
    end

    // Latch timeout, retry of same plane, then enable drop mid-display.
    do_plane(0, -1, 0, 0);
    do_plane(1, 2, 1, 0);
    for (int k = 0; k < 6; k++) begin
      bus.latch_in = (k == 1);
      step();
      check("idle_oe", bus.oe_n_out, 1);
      check("idle_no_fetch", bus.fb_rd_en_out, 0);
      check("idle_no_valid", bus.row_valid_out, 0);
    end
    bus.latch_in = 0;
    bus.enable_in = 1;
    step();
    do_plane(0, 3, 0, 0);

    // Reset in the middle of a display window.
    do_plane(0, 1, 0, 1);
    step();
    n_reset = 1;
    step();
    do_plane(0, 0, 0, 0);
    do_plane(2, 4, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
